ats_host: RTL and testbench
===========================

// Module: ats_host
// PURPOSE
//  Host-side initiator for the ATS alarm/timer service. Accepts commands from an upstream
//  controller, drives the ATS req/ctrlA/ctrlB command handshake, and returns each ATS
//  ready/stat result as a response. It also turns the ATS 24-bit alarm-finished vector into
//  sticky per-alarm pending flags with an interrupt line. Sits between CPU-side logic and ATS.
// PARAMETERS
//  NUM_ALARMS      24  width of ATS data vector / pending flags
//  CTRL_W          16  width of ctrlA/ctrlB and cmd_a/cmd_b
//  TIMEOUT_CYCLES  64  cycles in ISSUE without ready before abort (ATS_HOST_TIMEOUT_EN only)
// PORTS
//  clk         in   1           single clock
//  reset       in   1           synchronous, active-high
//  cmd_valid   in   1           upstream command valid
//  cmd_ready   out  1           host can accept command
//  cmd_a       in   CTRL_W      command word for ctrlA
//  cmd_b       in   CTRL_W      command word for ctrlB
//  rsp_valid   out  1           one-cycle response strobe
//  rsp_stat    out  2           ATS stat captured with ready
//  rsp_to      out  1           response is a timeout abort
//  req         out  1           ATS request
//  ctrlA       out  CTRL_W      ATS control word A
//  ctrlB       out  CTRL_W      ATS control word B
//  ready       in   1           ATS acknowledge, stat valid in same cycle
//  stat        in   2           ATS status
//  data        in   NUM_ALARMS  ATS alarm-finished bits (each high 2 cycles per event)
//  evt_pending out  NUM_ALARMS  sticky per-alarm event flags
//  evt_clr     in   NUM_ALARMS  write-1-to-clear for evt_pending
//  evt_ovf     out  1           sticky: event arrived on an already-pending alarm
//  evt_irq     out  1           registered OR of evt_pending
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1 from first post-reset cycle; FSM=IDLE; data history 0.
//  FSM IDLE->ISSUE->RESP->IDLE. cmd_ready = (state==IDLE).
//  IDLE: cmd_valid&cmd_ready at edge T latches cmd_a/cmd_b; req=1, ctrlA/ctrlB driven from T+1.
//  ISSUE: req, ctrlA, ctrlB held stable until ready sampled 1 at edge R; stat captured at R.
//  RESP (R+1): req=0, ctrlA/ctrlB=0, rsp_valid=1 for exactly 1 cycle, rsp_stat=captured, rsp_to=0.
//  Back to IDLE at R+2: req low >=1 cycle between commands; no back-to-back req.
//  ready while IDLE or RESP is ignored (no response, no state change).
//  ctrlA/ctrlB are 0 whenever req=0.
//  Events: data_q <= data; rise = data & ~data_q (2-cycle finished pulse counts once).
//  evt_pending <= (evt_pending & ~evt_clr) | rise; same-cycle rise and clear -> stays set.
//  evt_ovf set when any rise bit already set in evt_pending and not cleared that cycle;
//  cleared only by reset or evt_clr == all ones.
//  evt_irq = registered |evt_pending (1-cycle lag after pending).
//  Reset mid-command: req drops next edge, command discarded, no rsp_valid.
// CONFIGURATION
//  ATS_HOST_TIMEOUT_EN defined: 16-bit counter runs in ISSUE; ISSUE at TIMEOUT_CYCLES cycles
//   without ready -> RESP with rsp_to=1, rsp_stat=2'b00; ready on the same edge wins (normal rsp).
//  Not defined: ISSUE waits indefinitely; rsp_to tied 0; no counter logic.
// STRUCTURE
//  ats_pkg: host_state_e enum (IDLE, ISSUE, RESP), ATS stat code localparams, CTRL_W/NUM_ALARMS.
//  Sub-module ats_evt_capture: data_q, rise detect, evt_pending/evt_ovf/evt_irq.
//  Top holds the FSM, command latch and optional timeout counter.
// TESTING
//  1 cmd_a=16'h8001,cmd_b=16'h0005; ready=1,stat=2'b01 three cycles after req -> req high 3 cyc,
//    ctrlA/B stable, rsp_valid 1 cycle with rsp_stat=01, cmd_ready back 2 cycles after ready.
//  2 cmd_valid held high with 3 commands, ready after 1 cycle each -> req low >=1 cycle between;
//    3 responses in order; cmd_ready never 1 outside IDLE.
//  3 data[5] high 2 cycles -> evt_pending[5]=1 once, evt_irq 1 cycle later; evt_clr[5] -> 0.
//  4 data[7] rises on the cycle evt_clr[7]=1 while pending -> stays 1; second rise with
//    pending set -> evt_ovf=1; evt_clr=24'hFFFFFF -> evt_ovf=0.
//  5 reset asserted in ISSUE -> req=0 next edge, no rsp_valid, cmd_ready=1 after reset.
//  6 (TIMEOUT_EN, TIMEOUT_CYCLES=8) no ready -> rsp_valid with rsp_to=1 after 8 ISSUE cycles;
//    late ready ignored; without macro req stays high 100 cycles, no response.

Source files
------------

// File: rtl/ats_pkg.sv
// Shared widths, FSM state type and ATS status codes for the ATS host block.
package ats_pkg;

  localparam int CTRL_W     = 16;
  localparam int NUM_ALARMS = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } host_state_e;

  typedef enum logic [1:0] {
    ATS_STAT_NONE = 2'b00,
    ATS_STAT_DONE = 2'b01,
    ATS_STAT_BUSY = 2'b10,
    ATS_STAT_ERR  = 2'b11
  } ats_stat_e;

endpackage

// File: rtl/ats_evt_capture.sv
// Turns the ATS alarm-finished vector into sticky pending flags, an overflow flag
// and a registered interrupt line.
module ats_evt_capture
  import ats_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_ALARMS-1:0] data,
  input  logic [NUM_ALARMS-1:0] evt_clr,
  output logic [NUM_ALARMS-1:0] evt_pending,
  output logic                  evt_ovf,
  output logic                  evt_irq
);

  logic [NUM_ALARMS-1:0] data_q_r;
  logic [NUM_ALARMS-1:0] pending_r;
  logic [NUM_ALARMS-1:0] rise_s;
  logic                  ovf_r;
  logic                  irq_r;
  logic                  clr_all_s;
  logic                  ovf_hit_s;

  // A two-cycle finished pulse yields a single rise.
  assign rise_s    = data & ~data_q_r;
  assign clr_all_s = &evt_clr;
  assign ovf_hit_s = |(rise_s & pending_r & ~evt_clr);

  // Edge history, sticky pending/overflow flags and the lagged interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q_r  <= '0;
      pending_r <= '0;
      ovf_r     <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      data_q_r  <= data;
      pending_r <= (pending_r & ~evt_clr) | rise_s;
      if (clr_all_s) begin
        ovf_r <= 1'b0;
      end else if (ovf_hit_s) begin
        ovf_r <= 1'b1;
      end else begin
        ovf_r <= ovf_r;
      end
      irq_r <= |pending_r;
    end
  end

  assign evt_pending = pending_r;
  assign evt_ovf     = ovf_r;
  assign evt_irq     = irq_r;

endmodule

// File: rtl/ats_host.sv
// Host-side initiator for the ATS alarm/timer service: command handshake FSM plus event capture.
// Optional ISSUE timeout abort is built when ATS_HOST_TIMEOUT_EN is defined.
module ats_host
  import ats_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CTRL_W-1:0]     cmd_a,
  input  logic [CTRL_W-1:0]     cmd_b,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_stat,
  output logic                  rsp_to,
  output logic                  req,
  output logic [CTRL_W-1:0]     ctrlA,
  output logic [CTRL_W-1:0]     ctrlB,
  input  logic                  ready,
  input  logic [1:0]            stat,
  input  logic [NUM_ALARMS-1:0] data,
  output logic [NUM_ALARMS-1:0] evt_pending,
  input  logic [NUM_ALARMS-1:0] evt_clr,
  output logic                  evt_ovf,
  output logic                  evt_irq
);

  host_state_e       state_r;
  logic              req_r;
  logic [CTRL_W-1:0] ctrl_a_r;
  logic [CTRL_W-1:0] ctrl_b_r;
  logic              rsp_valid_r;
  logic [1:0]        rsp_stat_r;
  logic              to_hit_s;

`ifdef ATS_HOST_TIMEOUT_EN
  logic [15:0] to_cnt_r;
  logic        rsp_to_r;

  assign to_hit_s = (to_cnt_r == 16'(TIMEOUT_CYCLES - 1));

  // Counts ISSUE cycles; restarts whenever the FSM is elsewhere.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_r <= 16'd0;
    end else if (state_r == ISSUE) begin
      to_cnt_r <= to_cnt_r + 16'd1;
    end else begin
      to_cnt_r <= 16'd0;
    end
  end

  // Timeout flag accompanies the response strobe only.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_to_r <= 1'b0;
    end else if (state_r == ISSUE) begin
      rsp_to_r <= !ready && to_hit_s;
    end else begin
      rsp_to_r <= 1'b0;
    end
  end

  assign rsp_to = rsp_to_r;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign to_hit_s = 1'b0;
  assign rsp_to   = 1'b0;
`endif

  // Command FSM; ready wins over a timeout on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      req_r       <= 1'b0;
      ctrl_a_r    <= '0;
      ctrl_b_r    <= '0;
      rsp_valid_r <= 1'b0;
      rsp_stat_r  <= ATS_STAT_NONE;
    end else begin
      case (state_r)
        IDLE: begin
          rsp_valid_r <= 1'b0;
          if (cmd_valid) begin
            state_r  <= ISSUE;
            req_r    <= 1'b1;
            ctrl_a_r <= cmd_a;
            ctrl_b_r <= cmd_b;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (ready || to_hit_s) begin
            state_r     <= RESP;
            req_r       <= 1'b0;
            ctrl_a_r    <= '0;
            ctrl_b_r    <= '0;
            rsp_valid_r <= 1'b1;
            rsp_stat_r  <= ready ? stat : ATS_STAT_NONE;
          end else begin
            state_r <= ISSUE;
          end
        end
        RESP: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
          rsp_stat_r  <= ATS_STAT_NONE;
        end
        default: begin
          state_r     <= IDLE;
          req_r       <= 1'b0;
          ctrl_a_r    <= '0;
          ctrl_b_r    <= '0;
          rsp_valid_r <= 1'b0;
          rsp_stat_r  <= ATS_STAT_NONE;
        end
      endcase
    end
  end

  assign cmd_ready = (state_r == IDLE);
  assign req       = req_r;
  assign ctrlA     = ctrl_a_r;
  assign ctrlB     = ctrl_b_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_stat  = rsp_stat_r;

  ats_evt_capture u_evt (
    .clk         (clk),
    .reset       (reset),
    .data        (data),
    .evt_clr     (evt_clr),
    .evt_pending (evt_pending),
    .evt_ovf     (evt_ovf),
    .evt_irq     (evt_irq)
  );

endmodule

// File: tb/tb_ats_host.sv
// Self-checking bench for ats_host: directed scenarios plus randomized command and event traffic.
module tb_ats_host;
  import ats_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        rsp_valid;
  logic [1:0]  rsp_stat;
  logic        rsp_to;
  logic        req;
  logic [15:0] ctrlA;
  logic [15:0] ctrlB;
  logic        ready;
  logic [1:0]  stat;
  logic [23:0] data;
  logic [23:0] evt_pending;
  logic [23:0] evt_clr;
  logic        evt_ovf;
  logic        evt_irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ats_host #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .rsp_valid(rsp_valid), .rsp_stat(rsp_stat),
    .rsp_to(rsp_to), .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB), .ready(ready),
    .stat(stat), .data(data), .evt_pending(evt_pending), .evt_clr(evt_clr),
    .evt_ovf(evt_ovf), .evt_irq(evt_irq)
  );

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_a = 16'h0; cmd_b = 16'h0;
    ready = 1'b0; stat = 2'b00; data = 24'h0; evt_clr = 24'h0;
    repeat (2) @(negedge clk);
    total++;
    if ({req, rsp_valid, rsp_to, evt_ovf, evt_irq} !== 5'b0 || ctrlA !== 16'h0 ||
        ctrlB !== 16'h0 || evt_pending !== 24'h0 || rsp_stat !== 2'b00) begin
      bad++; $display("FAIL reset_outputs: req=%b rsp=%b ctrlA=%h pend=%h", req, rsp_valid, ctrlA, evt_pending);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got=%b want=1", cmd_ready); end
  endtask

  task automatic test_basic();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = 16'h8001; cmd_b = 16'h0005;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      total++;
      if (req !== 1'b1 || ctrlA !== 16'h8001 || ctrlB !== 16'h0005 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
        bad++; $display("FAIL basic_issue%0d: req=%b ctrlA=%h ctrlB=%h cmd_ready=%b want 1/8001/0005/0", i, req, ctrlA, ctrlB, cmd_ready);
      end
      if (i == 2) begin ready = 1'b1; stat = 2'b01; end
    end
    @(negedge clk);
    ready = 1'b0; stat = 2'b00;
    total++;
    if (req !== 1'b0 || ctrlA !== 16'h0 || ctrlB !== 16'h0 || rsp_valid !== 1'b1 ||
        rsp_stat !== 2'b01 || rsp_to !== 1'b0 || cmd_ready !== 1'b0) begin
      bad++; $display("FAIL basic_rsp: req=%b rsp_valid=%b rsp_stat=%b rsp_to=%b cmd_ready=%b want 0/1/01/0/0", req, rsp_valid, rsp_stat, rsp_to, cmd_ready);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL basic_return: rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_back_to_back(input int n);
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [1:0]  qs[$];
    logic [15:0] na, nb;
    int sent = 0, got = 0, cd = -1, hi = 0, exp_hi = 0, cyc = 0;
    bit rsp_due = 1'b0, acc = 1'b0, prev_req = 1'b0;
    na = 16'($urandom); nb = 16'($urandom);
    while (got < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      total++;
      if (rsp_valid !== rsp_due) begin bad++; $display("FAIL b2b_rsp_valid: got=%b want=%b", rsp_valid, rsp_due); end
      if (rsp_due) begin
        total++;
        if (rsp_stat !== qs[0] || rsp_to !== 1'b0) begin
          bad++; $display("FAIL b2b_rsp_stat: got=%b to=%b want=%b to=0", rsp_stat, rsp_to, qs[0]);
        end
        void'(qs.pop_front());
        got++;
      end
      total++;
      if (cmd_ready === 1'b1 && (req !== 1'b0 || rsp_valid !== 1'b0)) begin
        bad++; $display("FAIL b2b_cmd_ready: cmd_ready=1 with req=%b rsp_valid=%b", req, rsp_valid);
      end
      if (req === 1'b1) begin
        hi++;
        total++;
        if (qa.size() == 0 || ctrlA !== qa[0] || ctrlB !== qb[0]) begin
          bad++; $display("FAIL b2b_ctrl: got a=%h b=%h queued=%0d", ctrlA, ctrlB, qa.size());
        end
      end else begin
        total++;
        if (ctrlA !== 16'h0 || ctrlB !== 16'h0) begin
          bad++; $display("FAIL b2b_ctrl_idle: got a=%h b=%h want 0", ctrlA, ctrlB);
        end
        if (prev_req) begin
          total++;
          if (hi != exp_hi) begin bad++; $display("FAIL b2b_req_len: got=%0d want=%0d", hi, exp_hi); end
          hi = 0;
          if (qa.size() != 0) begin void'(qa.pop_front()); void'(qb.pop_front()); end
        end
      end
      // ATS side: answer each request after a random delay; stray ready pulses when idle.
      rsp_due = 1'b0;
      ready = 1'b0;
      stat = 2'($urandom);
      if (req === 1'b1) begin
        if (cd < 0) begin cd = int'($urandom_range(0, 4)); exp_hi = cd + 1; end
        if (cd == 0) begin ready = 1'b1; qs.push_back(stat); rsp_due = 1'b1; cd = -1; end
        else cd--;
      end else if ($urandom_range(0, 3) == 0) begin
        ready = 1'b1;
      end
      if (acc) begin na = 16'($urandom); nb = 16'($urandom); acc = 1'b0; end
      cmd_valid = (sent < n);
      cmd_a = na; cmd_b = nb;
      if (cmd_valid && cmd_ready === 1'b1) begin
        qa.push_back(na); qb.push_back(nb); sent++; acc = 1'b1;
      end
      prev_req = req;
    end
    cmd_valid = 1'b0; ready = 1'b0;
    total++;
    if (got != n) begin bad++; $display("FAIL b2b_count: got=%0d want=%0d", got, n); end
  endtask

  task automatic test_evt_single();
    @(negedge clk); evt_clr = 24'hFFFFFF; data = 24'h0;
    @(negedge clk); evt_clr = 24'h0; data = 24'h000020;
    @(negedge clk);
    total++;
    if (evt_pending !== 24'h000020 || evt_irq !== 1'b0) begin
      bad++; $display("FAIL evt5_set: pend=%h irq=%b want 000020/0", evt_pending, evt_irq);
    end
    @(negedge clk); data = 24'h0;
    total++;
    if (evt_pending !== 24'h000020 || evt_irq !== 1'b1 || evt_ovf !== 1'b0) begin
      bad++; $display("FAIL evt5_hold: pend=%h irq=%b ovf=%b want 000020/1/0", evt_pending, evt_irq, evt_ovf);
    end
    evt_clr = 24'h000020;
    @(negedge clk); evt_clr = 24'h0;
    total++;
    if (evt_pending !== 24'h0) begin bad++; $display("FAIL evt5_clr: pend=%h want 0", evt_pending); end
    @(negedge clk);
    total++;
    if (evt_irq !== 1'b0) begin bad++; $display("FAIL evt5_irq_off: irq=%b want 0", evt_irq); end
  endtask

  task automatic test_evt_collision();
    @(negedge clk); evt_clr = 24'hFFFFFF; data = 24'h0;
    @(negedge clk); evt_clr = 24'h0; data = 24'h000080;
    @(negedge clk);
    total++;
    if (evt_pending !== 24'h000080 || evt_ovf !== 1'b0) begin
      bad++; $display("FAIL evt7_first: pend=%h ovf=%b want 000080/0", evt_pending, evt_ovf);
    end
    @(negedge clk); data = 24'h0;
    @(negedge clk); data = 24'h000080; evt_clr = 24'h000080;
    @(negedge clk); evt_clr = 24'h0;
    total++;
    if (evt_pending !== 24'h000080 || evt_ovf !== 1'b0) begin
      bad++; $display("FAIL evt7_rise_clr: pend=%h ovf=%b want 000080/0", evt_pending, evt_ovf);
    end
    @(negedge clk); data = 24'h0;
    @(negedge clk); data = 24'h000080;
    @(negedge clk);
    total++;
    if (evt_ovf !== 1'b1 || evt_pending !== 24'h000080) begin
      bad++; $display("FAIL evt7_ovf: ovf=%b pend=%h want 1/000080", evt_ovf, evt_pending);
    end
    @(negedge clk); data = 24'h0; evt_clr = 24'hFFFFFF;
    @(negedge clk); evt_clr = 24'h0;
    total++;
    if (evt_ovf !== 1'b0 || evt_pending !== 24'h0) begin
      bad++; $display("FAIL evt7_clr_all: ovf=%b pend=%h want 0/0", evt_ovf, evt_pending);
    end
  endtask

  task automatic test_evt_random(input int cycles);
    logic [23:0] pend_m = 24'h0, d, clr, st;
    bit ovf_m = 1'b0, irq_m = 1'b0;
    int left[24];
    bit gap[24];
    @(negedge clk); reset = 1'b1; data = 24'h0; evt_clr = 24'h0;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 24; i++) begin left[i] = 0; gap[i] = 1'b0; end
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      total++;
      if (evt_pending !== pend_m || evt_ovf !== ovf_m || evt_irq !== irq_m) begin
        bad++; $display("FAIL evt_rand c=%0d: pend=%h ovf=%b irq=%b want %h/%b/%b", c, evt_pending, evt_ovf, evt_irq, pend_m, ovf_m, irq_m);
      end
      // Each alarm event is a 2-cycle high pulse followed by at least one low cycle.
      st = 24'h0;
      for (int i = 0; i < 24; i++) begin
        if (left[i] != 0) begin d[i] = 1'b1; left[i]--; if (left[i] == 0) gap[i] = 1'b1; end
        else if (gap[i]) begin d[i] = 1'b0; gap[i] = 1'b0; end
        else if ($urandom_range(0, 15) == 0) begin d[i] = 1'b1; st[i] = 1'b1; left[i] = 1; end
        else d[i] = 1'b0;
      end
      clr = ($urandom_range(0, 3) == 0) ? (24'($urandom) & 24'($urandom)) : 24'h0;
      if ($urandom_range(0, 39) == 0) clr = 24'hFFFFFF;
      data = d; evt_clr = clr;
      irq_m = |pend_m;
      if (clr == 24'hFFFFFF) ovf_m = 1'b0;
      else if (|(st & pend_m & ~clr)) ovf_m = 1'b1;
      pend_m = (pend_m & ~clr) | st;
    end
    @(negedge clk); data = 24'h0; evt_clr = 24'h0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk); cmd_valid = 1'b1; cmd_a = 16'($urandom); cmd_b = 16'($urandom); ready = 1'b0;
    @(negedge clk); cmd_valid = 1'b0;
    total++;
    if (req !== 1'b1) begin bad++; $display("FAIL rstmid_start: req=%b want 1", req); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); ready = 1'b1;
    total++;
    if (req !== 1'b0 || ctrlA !== 16'h0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_drop: req=%b ctrlA=%h rsp_valid=%b cmd_ready=%b want 0/0/0/1", req, ctrlA, rsp_valid, cmd_ready);
    end
    @(negedge clk); reset = 1'b0; ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0 || req !== 1'b0 || cmd_ready !== 1'b1) begin
        bad++; $display("FAIL rstmid_after%0d: rsp_valid=%b req=%b cmd_ready=%b want 0/0/1", i, rsp_valid, req, cmd_ready);
      end
    end
  endtask

  task automatic test_timeout();
    int hi;
`ifdef ATS_HOST_TIMEOUT_EN
    @(negedge clk); cmd_valid = 1'b1; cmd_a = 16'h1234; cmd_b = 16'h5678; ready = 1'b0;
    @(negedge clk); cmd_valid = 1'b0;
    hi = 0;
    for (int k = 0; k < 50 && req === 1'b1; k++) begin hi++; @(negedge clk); end
    total++;
    if (hi != 8 || rsp_valid !== 1'b1 || rsp_to !== 1'b1 || rsp_stat !== 2'b00) begin
      bad++; $display("FAIL to_abort: req_cycles=%0d rsp_valid=%b rsp_to=%b stat=%b want 8/1/1/00", hi, rsp_valid, rsp_to, rsp_stat);
    end
    ready = 1'b1; stat = 2'b11;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0 || rsp_to !== 1'b0 || req !== 1'b0) begin
        bad++; $display("FAIL to_late_ready%0d: rsp_valid=%b rsp_to=%b req=%b want 0/0/0", i, rsp_valid, rsp_to, req);
      end
    end
    ready = 1'b0;
    @(negedge clk); cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin ready = 1'b1; stat = 2'b11; end
      @(negedge clk);
    end
    ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_to !== 1'b0 || rsp_stat !== 2'b11) begin
      bad++; $display("FAIL to_ready_wins: rsp_valid=%b rsp_to=%b stat=%b want 1/0/11", rsp_valid, rsp_to, rsp_stat);
    end
    @(negedge clk);
`else
    @(negedge clk); cmd_valid = 1'b1; cmd_a = 16'h1234; cmd_b = 16'h5678; ready = 1'b0;
    @(negedge clk); cmd_valid = 1'b0;
    hi = 0;
    for (int k = 0; k < 100; k++) begin
      if (req === 1'b1 && rsp_valid === 1'b0) hi++;
      @(negedge clk);
    end
    total++;
    if (hi != 100) begin bad++; $display("FAIL noto_wait: req_cycles=%0d want 100", hi); end
    ready = 1'b1; stat = 2'b10;
    @(negedge clk); ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_to !== 1'b0 || rsp_stat !== 2'b10) begin
      bad++; $display("FAIL noto_rsp: rsp_valid=%b rsp_to=%b stat=%b want 1/0/10", rsp_valid, rsp_to, rsp_stat);
    end
    @(negedge clk);
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back(40);
    test_evt_single();
    test_evt_collision();
    test_evt_random(400);
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
